button_conditioner: RTL and testbench

//  Front-end conditioning for the clock's raw board buttons and mode switches.

---
 rtl/clk_pkg.sv | 28 ++
 rtl/btn_debounce_ch.sv | 108 ++++++++++
 rtl/button_conditioner.sv | 54 +++++
 tb/tb_button_conditioner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared definitions for the clock front-end: button channel states, button
// indices and default timing constants.
package clk_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_MODIFY = 2;

    localparam int DEF_NUM_BTN         = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 20_000_000;
    localparam int DEF_SW_WIDTH        = 4;
    localparam logic [2:0] DEF_REPEAT_MASK = 3'b011;

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One already-synchronised button channel: debounce FSM with optional
// hold-to-repeat strobes.
//
// state     | meaning
// IDLE      | released, waiting for s=1
// PRESS_CHK | s=1 seen, counting stable-high cycles before accepting
// HELD      | press accepted, level=1, repeat counter running
// REL_CHK   | s=0 seen while held, counting stable-low cycles; repeat suspended
module btn_debounce_ch
    import clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic level,
    output logic pulse
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int RPT_W = cnt_width(REPEAT_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    btn_state_t       state, state_d;
    logic [DB_W-1:0]  db_cnt, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_d;
    logic             level_d, pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            db_cnt  <= '0;
            rpt_cnt <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state   <= state_d;
            db_cnt  <= db_cnt_d;
            rpt_cnt <= rpt_cnt_d;
            level   <= level_d;
            pulse   <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state;
        db_cnt_d  = db_cnt;
        rpt_cnt_d = rpt_cnt;
        case (state)
            IDLE: begin
                if (s) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_d   = HELD;
                    rpt_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d  = REL_CHK;
                    db_cnt_d = '0;
                end else if (REPEAT_EN) begin
                    // Reloading keeps the counter inside 0..RPT_LAST, so it cannot wrap.
                    if (rpt_cnt == RPT_LAST) begin
                        rpt_cnt_d = RPT_RELOAD;
                    end else if (rpt_cnt < RPT_LAST) begin
                        rpt_cnt_d = rpt_cnt + 1'b1;
                    end
                end
            end
            REL_CHK: begin
                if (s) begin
                    state_d = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = (state_d == HELD) || (state_d == REL_CHK);
        pulse_d = 1'b0;
        if (state == PRESS_CHK && s && db_cnt == DB_LAST) begin
            pulse_d = 1'b1;
        end else if (REPEAT_EN && state == HELD && s && rpt_cnt == RPT_LAST) begin
            pulse_d = 1'b1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Board button and mode-switch front end: 2-FF synchronisers plus one
// debounce/repeat channel per button.
module button_conditioner
    import clk_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = DEF_REPEAT_MASK,
    parameter int SW_WIDTH        = DEF_SW_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTN-1:0]  btn_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [NUM_BTN-1:0]  btn_level,
    output logic [NUM_BTN-1:0]  btn_pulse,
    output logic [SW_WIDTH-1:0] sw_sync
);

    logic [NUM_BTN-1:0]  btn_s1, btn_s2;
    logic [SW_WIDTH-1:0] sw_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            sw_s1   <= sw_raw;
            sw_sync <= sw_s1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .s     (btn_s2[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int SW = 4;
    localparam int D  = 4;
    localparam int RD = 12;
    localparam int RP = 5;
    localparam logic [NB-1:0] MASK = 3'b011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [SW-1:0] sw_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic [SW-1:0] sw_sync;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK),
        .SW_WIDTH        (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .sw_sync   (sw_sync)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a level flips after D+1 consecutive synchronised samples
    // of the opposite value; repeats count held samples that follow a held sample.
    logic [NB-1:0] m_b1, m_b2, m_prev, m_level, m_pulse;
    logic [SW-1:0] m_sw1, m_sw2;
    int            m_run  [NB];
    int            m_hcnt [NB];

    task automatic model_reset();
        m_b1 = '0; m_b2 = '0; m_prev = '0; m_level = '0; m_pulse = '0;
        m_sw1 = '0; m_sw2 = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
            m_hcnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NB; i++) begin
            s = m_b2[i];
            m_pulse[i] = 1'b0;
            if (s != m_level[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == D + 1) begin
                m_run[i] = 0;
                m_level[i] = ~m_level[i];
                if (m_level[i]) begin
                    m_pulse[i] = 1'b1;
                    m_hcnt[i] = 0;
                end
            end else if (m_level[i] && s && m_prev[i] && MASK[i]) begin
                m_hcnt[i]++;
                if (m_hcnt[i] == RD || (m_hcnt[i] > RD && (m_hcnt[i] - RD) % RP == 0))
                    m_pulse[i] = 1'b1;
            end
            m_prev[i] = s;
        end
        m_b2 = m_b1;
        m_b1 = btn_raw;
        m_sw2 = m_sw1;
        m_sw1 = sw_raw;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model_level", int'(btn_level), int'(m_level));
        check("model_pulse", int'(btn_pulse), int'(m_pulse));
        check("model_sw",    int'(sw_sync),   int'(m_sw2));
    endtask

    task automatic check_zero(input string name);
        check({name, "_level"}, int'(btn_level), 0);
        check({name, "_pulse"}, int'(btn_pulse), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_async");
        check("rst_async_sw", int'(sw_sync), 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_queue(input string name, input int got[$], input int exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check({name, "_cycle"}, got[i], exp[i]);
    endtask

    typedef struct {
        logic          rst_n;
        logic [NB-1:0] btn;
        logic [SW-1:0] sw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] pls;
        logic [SW-1:0] sws;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int q[$];
        int q2[$];
        int fall_at;
        rst_n = 1'b0;
        btn_raw = '0;
        sw_raw = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset with all buttons pressed, then acceptance after edge 6.
        tbl[0] = '{1'b0, 3'b111, 4'b0101, 3'b000, 3'b000, 4'b0000};
        tbl[1] = '{1'b1, 3'b111, 4'b0101, 3'b000, 3'b000, 4'b0000};
        tbl[2] = '{1'b1, 3'b111, 4'b0101, 3'b000, 3'b000, 4'b0101};
        tbl[3] = '{1'b1, 3'b111, 4'b0101, 3'b000, 3'b000, 4'b0101};
        tbl[4] = '{1'b1, 3'b111, 4'b0101, 3'b000, 3'b000, 4'b0101};
        tbl[5] = '{1'b1, 3'b111, 4'b0101, 3'b000, 3'b000, 4'b0101};
        tbl[6] = '{1'b1, 3'b111, 4'b0101, 3'b000, 3'b000, 4'b0101};
        tbl[7] = '{1'b1, 3'b111, 4'b0101, 3'b111, 3'b111, 4'b0101};
        tbl[8] = '{1'b1, 3'b111, 4'b0101, 3'b111, 3'b000, 4'b0101};
        tbl[9] = '{1'b1, 3'b111, 4'b0101, 3'b111, 3'b000, 4'b0101};
        for (int r = 0; r < 10; r++) begin
            rst_n = tbl[r].rst_n;
            btn_raw = tbl[r].btn;
            sw_raw = tbl[r].sw;
            if (!rst_n) model_reset();
            step();
            check("tbl_level", int'(btn_level), int'(tbl[r].lvl));
            check("tbl_pulse", int'(btn_pulse), int'(tbl[r].pls));
            check("tbl_sw",    int'(sw_sync),   int'(tbl[r].sws));
        end

        // Fast toggling on modify is rejected.
        btn_raw = '0;
        sw_raw = '0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            btn_raw = {((c / 2) % 2 == 1), 2'b00};
            step();
            check("bounce_level2", int'(btn_level[2]), 0);
            check("bounce_pulse2", int'(btn_pulse[2]), 0);
        end

        // Hold-to-repeat on up, single pulse on modify.
        btn_raw = '0;
        do_reset();
        q = {};
        q2 = {};
        for (int c = 0; c < 48; c++) begin
            btn_raw = 3'b101;
            step();
            if (btn_pulse[0]) q.push_back(c);
            if (btn_pulse[2]) q2.push_back(c);
        end
        check_queue("repeat_up", q, '{6, 18, 23, 28, 33, 38, 43});
        check_queue("repeat_modify", q2, '{6});

        // Down held with a 2-cycle release glitch: repeat suspended, not restarted.
        btn_raw = '0;
        do_reset();
        q = {};
        for (int c = 0; c < 46; c++) begin
            btn_raw = (c == 21 || c == 22) ? 3'b000 : 3'b010;
            step();
            if (btn_pulse[1]) q.push_back(c);
            if (c >= 6) check("glitch_level1", int'(btn_level[1]), 1);
        end
        check_queue("glitch_down", q, '{6, 18, 26, 31, 36, 41});

        // Release latency.
        btn_raw = '0;
        do_reset();
        btn_raw = 3'b001;
        repeat (10) step();
        btn_raw = 3'b000;
        fall_at = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (fall_at < 0 && !btn_level[0]) fall_at = k;
            check("release_pulse0", int'(btn_pulse[0]), 0);
        end
        check("release_latency", fall_at, 6);

        // Reset mid-debounce and mid-hold, then switch sync latency.
        btn_raw = '0;
        do_reset();
        btn_raw = 3'b001;
        repeat (4) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_press_chk");
        step();
        rst_n = 1'b1;
        q = {};
        for (int c = 0; c < 9; c++) begin
            step();
            if (btn_pulse[0]) q.push_back(c);
        end
        check_queue("requalify", q, '{6});
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_held");
        step();
        btn_raw = 3'b000;
        rst_n = 1'b1;
        repeat (8) step();
        check_zero("after_rst_held");
        sw_raw = 4'b0101;
        step();
        check("sw_edge1", int'(sw_sync), 0);
        step();
        check("sw_edge2", int'(sw_sync), 5);

        // Randomised run against the model.
        btn_raw = '0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(15) == 0) btn_raw[i] = ~btn_raw[i];
            sw_raw = SW'($urandom);
            if ($urandom_range(499) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
